load_store_unit: RTL

//  Multi-cycle data-memory access stage sitting directly downstream of the control unit and ALU.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Word-wide req/ack data bus with byte enables.
// The LSU is master; memory or the bench is slave.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_be,
    output bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_be,
    input  bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: stalls the core, runs one
// req/ack bus access, returns extended load data on done.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mem_op,
  input  logic        is_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err_misalign,
  output logic        err_timeout,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_m_q, err_m_d;
  logic        err_t_q, err_t_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  lane_q, lane_d;
  logic        ld_q, ld_d;
  logic        byte_q, byte_d;
  logic        sext_q, sext_d;

  logic [3:0]  op;
  logic        is_lw, is_sw, is_lb, is_sb, is_lbu;
  logic        op_ok, op_word, op_byte;
  logic        misal;
  logic [7:0]  rd_byte;
  logic [31:0] ld_val;

  assign op      = {is_load, mem_op};
  assign is_lw   = (op == 4'b1000);
  assign is_sw   = (op == 4'b0001);
  assign is_lb   = (op == 4'b1010);
  assign is_sb   = (op == 4'b0011);
  assign is_lbu  = (op == 4'b1110);
  assign op_word = is_lw | is_sw;
  assign op_byte = is_lb | is_sb | is_lbu;
  assign op_ok   = op_word | op_byte;
  assign misal   = op_word & (addr[1:0] != 2'b00);

  assign rd_byte = bus.bus_rdata[{lane_q, 3'b000} +: 8];

  // Shape the returned word for the pending load kind
  always_comb begin
    ld_val = bus.bus_rdata;
    unique case (1'b1)
      !byte_q: ld_val = bus.bus_rdata;
      sext_q:  ld_val = {{24{rd_byte[7]}}, rd_byte};
      default: ld_val = {24'h0, rd_byte};
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_m_d = err_m_q;
    err_t_d = err_t_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    ld_d    = ld_q;
    byte_d  = byte_q;
    sext_d  = sext_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && op_ok) begin
          stall = 1'b1;
          if (misal) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_m_d = 1'b1;
            err_t_d = 1'b0;
            rdata_d = 32'h0;
          end else begin
            state_d = REQ;
            count_d = 8'h0;
            req_d   = 1'b1;
            we_d    = is_sw | is_sb;
            be_d    = is_sb ? (4'b0001 << addr[1:0])
                            : 4'hF;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = is_sb ? {4{wdata[7:0]}} : wdata;
            lane_d  = addr[1:0];
            ld_d    = is_load;
            byte_d  = op_byte;
            sext_d  = is_lb;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        count_d = count_q + 8'h1;
        if (bus.bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_m_d = 1'b0;
          err_t_d = 1'b0;
          rdata_d = ld_q ? ld_val : 32'h0;
        end else if (count_q == LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_m_d = 1'b0;
          err_t_d = 1'b1;
          rdata_d = 32'h0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 8'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_m_q <= 1'b0;
      err_t_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lane_q  <= 2'b00;
      ld_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_m_q <= err_m_d;
      err_t_q <= err_t_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      ld_q    <= ld_d;
      byte_q  <= byte_d;
      sext_q  <= sext_d;
    end
  end

  assign rdata         = rdata_q;
  assign done          = done_q;
  assign err_misalign  = err_m_q;
  assign err_timeout   = err_t_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule
